// File: rtl/gshare_predictor.sv
// gshare branch predictor: global history XOR address indexes a table
// of saturating counters; history trains only on resolved branches.
module gshare_predictor #(
  parameter int ADDR_WIDTH    = 4,
  parameter int HIST_WIDTH    = 4,
  parameter int COUNTER_WIDTH = 2,
  localparam int GW = (HIST_WIDTH > 0) ? HIST_WIDTH : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  input  logic [ADDR_WIDTH-1:0] pred_address,
  output logic                  prediction,
  output logic                  prediction_valid,
  output logic [ADDR_WIDTH-1:0] prediction_index,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_index,
  input  logic                  upd_result,
  output logic [GW-1:0]         ghr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [COUNTER_WIDTH-1:0] CMAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CINIT =
    COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);

  logic [COUNTER_WIDTH-1:0] counters [DEPTH];
  logic [COUNTER_WIDTH-1:0] ctr_cur;
  logic [COUNTER_WIDTH-1:0] ctr_next;
  logic [ADDR_WIDTH-1:0]    lookup_index;

  generate
    if (HIST_WIDTH == 0) begin : g_bimodal
      // No history: the table is indexed directly by address.
      assign lookup_index = pred_address;
      assign ghr          = '0;
    end else begin : g_gshare
      logic [HIST_WIDTH-1:0] ghr_q;

      assign lookup_index = pred_address ^ ADDR_WIDTH'(ghr_q);
      assign ghr          = ghr_q;

      if (HIST_WIDTH == 1) begin : g_h1
        // One-bit history just remembers the last outcome.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ghr_q <= '0;
          end else if (upd_valid) begin
            ghr_q <= upd_result;
          end
        end
      end else begin : g_hn
        // Shift in the resolved outcome, newest at bit 0.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ghr_q <= '0;
          end else if (upd_valid) begin
            ghr_q <= {ghr_q[HIST_WIDTH-2:0], upd_result};
          end
        end
      end
    end
  endgenerate

  assign ctr_cur = counters[upd_index];

  // Saturating step of the counter being trained.
  always_comb begin
    ctr_next = ctr_cur;
    unique case (1'b1)
      upd_result && (ctr_cur != CMAX):
        ctr_next = ctr_cur + COUNTER_WIDTH'(1);
      !upd_result && (ctr_cur != '0):
        ctr_next = ctr_cur - COUNTER_WIDTH'(1);
      default:
        ctr_next = ctr_cur;
    endcase
  end

  // Counter table: reset to weakly not-taken, one write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        counters[i] <= CINIT;
      end
    end else if (upd_valid) begin
      counters[upd_index] <= ctr_next;
    end
  end

  // Registered lookup; reads pre-edge table (no bypass).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prediction       <= 1'b0;
      prediction_index <= '0;
      prediction_valid <= 1'b0;
    end else begin
      prediction_valid <= pred_valid;
      if (pred_valid) begin
        prediction       <= counters[lookup_index][COUNTER_WIDTH-1];
        prediction_index <= lookup_index;
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized bench for gshare_predictor with a behavioural table model;
// a history-free build runs alongside as a bimodal reference.
module tb_gshare_predictor;

  localparam int AW   = 4;
  localparam int HW   = 4;
  localparam int CW   = 2;
  localparam int N    = 1 << AW;
  localparam int MAXC = (1 << CW) - 1;
  localparam int INIT = (1 << (CW - 1)) - 1;
  localparam int HALF = 1 << (CW - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          pred_valid;
  logic [AW-1:0] pred_address;
  logic          upd_valid;
  logic [AW-1:0] upd_index;
  logic          upd_result;

  logic          prediction;
  logic          prediction_valid;
  logic [AW-1:0] prediction_index;
  logic [HW-1:0] ghr;

  logic          prediction0;
  logic          prediction_valid0;
  logic [AW-1:0] prediction_index0;
  logic [0:0]    ghr0;

  gshare_predictor #(
    .ADDR_WIDTH(AW), .HIST_WIDTH(HW), .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_address(pred_address),
    .prediction(prediction), .prediction_valid(prediction_valid),
    .prediction_index(prediction_index),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_result(upd_result), .ghr(ghr)
  );

  gshare_predictor #(
    .ADDR_WIDTH(AW), .HIST_WIDTH(0), .COUNTER_WIDTH(CW)
  ) dut0 (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_address(pred_address),
    .prediction(prediction0), .prediction_valid(prediction_valid0),
    .prediction_index(prediction_index0),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_result(upd_result), .ghr(ghr0)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: [0] = gshare table, [1] = bimodal table.
  int cnt [2][N];
  int hist;
  int e_pv;
  int e_pred [2];
  int e_pidx [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) cnt[m][i] = INIT;
      e_pred[m] = 0;
      e_pidx[m] = 0;
    end
    hist = 0;
    e_pv = 0;
  endtask

  task automatic compare_all();
    check("pred_valid", int'(prediction_valid), e_pv);
    check("prediction", int'(prediction), e_pred[0]);
    check("pred_index", int'(prediction_index), e_pidx[0]);
    check("ghr", int'(ghr), hist);
    check("pred_valid_h0", int'(prediction_valid0), e_pv);
    check("prediction_h0", int'(prediction0), e_pred[1]);
    check("pred_index_h0", int'(prediction_index0), e_pidx[1]);
    check("ghr_h0", int'(ghr0), 0);
  endtask

  // One clock: drive after negedge, advance model, compare after posedge.
  task automatic step(input bit pv, input int pa, input bit uv,
                      input int ui, input bit ur);
    int ix [2];
    pred_valid   = pv;
    pred_address = AW'(pa);
    upd_valid    = uv;
    upd_index    = AW'(ui);
    upd_result   = ur;
    e_pv = pv;
    if (pv) begin
      ix[0] = (pa ^ hist) % N;
      ix[1] = pa % N;
      for (int m = 0; m < 2; m++) begin
        e_pred[m] = (cnt[m][ix[m]] >= HALF) ? 1 : 0;
        e_pidx[m] = ix[m];
      end
    end
    if (uv) begin
      for (int m = 0; m < 2; m++) begin
        if (ur) cnt[m][ui] = (cnt[m][ui] < MAXC) ? cnt[m][ui] + 1 : MAXC;
        else    cnt[m][ui] = (cnt[m][ui] > 0) ? cnt[m][ui] - 1 : 0;
      end
      hist = ((hist << 1) | int'(ur)) % (1 << HW);
    end
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
           1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst          = 1'b1;
    pred_valid   = 1'b0;
    pred_address = '0;
    upd_valid    = 1'b0;
    upd_index    = '0;
    upd_result   = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Lookup at address 3 straight after reset.
    step(1'b1, 3, 1'b0, 0, 1'b0);
    check("lit_r31_pred", int'(prediction), 0);
    check("lit_r31_pv", int'(prediction_valid), 1);
    check("lit_r31_idx", int'(prediction_index), 3);
    idle();
    check("lit_pv_drop", int'(prediction_valid), 0);

    // Two taken updates at index 5, then lookup address 6.
    step(1'b0, 0, 1'b1, 5, 1'b1);
    step(1'b0, 0, 1'b1, 5, 1'b1);
    check("lit_r32_ghr", int'(ghr), 3);
    step(1'b1, 6, 1'b0, 0, 1'b0);
    check("lit_r32_pred", int'(prediction), 1);
    check("lit_r32_idx", int'(prediction_index), 5);

    // Saturation at index 0 in both directions.
    for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1, 0, 1'b1);
    check("lit_sat_hi_model", cnt[0][0], 3);
    step(1'b1, hist, 1'b0, 0, 1'b0);
    check("lit_sat_hi_pred", int'(prediction), 1);
    for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1, 0, 1'b0);
    check("lit_sat_lo_model", cnt[0][0], 0);
    step(1'b1, hist, 1'b0, 0, 1'b0);
    check("lit_sat_lo_pred", int'(prediction), 0);
    check("lit_sat_lo_idx", int'(prediction_index), 0);

    // Same-cycle lookup and update of index 2 (counter 1).
    step(1'b1, 2 ^ hist, 1'b1, 2, 1'b1);
    check("lit_rbw_old", int'(prediction), 0);
    check("lit_rbw_idx", int'(prediction_index), 2);
    step(1'b1, 2 ^ hist, 1'b0, 0, 1'b0);
    check("lit_rbw_new", int'(prediction), 1);

    random_cycles(400);

    // Asynchronous reset between edges, with an update held during it.
    step(1'b1, 5, 1'b1, 7, 1'b1);
    #2;
    rst        = 1'b1;
    upd_valid  = 1'b1;
    upd_index  = AW'(4);
    upd_result = 1'b1;
    pred_valid = 1'b1;
    #1;
    model_reset();
    check("async_pv", int'(prediction_valid), 0);
    check("async_pred", int'(prediction), 0);
    check("async_idx", int'(prediction_index), 0);
    check("async_ghr", int'(ghr), 0);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) step(1'b1, i, 1'b0, 0, 1'b0);
    check("lit_post_rst_pred", int'(prediction), 0);

    random_cycles(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
